// File: rtl/sram_req_responder.sv
// Responder for single-word datapath read/write requests onto a pipelined ZBT SRAM.
// Arbitrates one op per cycle and returns acks, read data and write-bus enables at fixed latency.
module sram_req_responder #(
  parameter int DATA_WIDTH      = 64,
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_RD_LAT     = 2,
  parameter int SRAM_WR_LAT     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
  output logic                       rd_0_ack,
  output logic [DATA_WIDTH-1:0]      rd_0_data,
  output logic                       rd_0_vld,
  input  logic                       wr_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
  input  logic [DATA_WIDTH-1:0]      wr_0_data,
  output logic                       wr_0_ack,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic [DATA_WIDTH-1:0]      sram_wr_data,
  output logic                       sram_tri_en,
  input  logic [DATA_WIDTH-1:0]      sram_rd_data
);

  // Handshake: a requester raises req with stable address/data and holds it until
  // the matching ack pulse; the ack cycle is the transfer. A req still high during
  // its own ack cycle is ignored, so a registered requester never gets a duplicate.

  logic                  rd_elig;
  logic                  wr_elig;
  logic                  grant_rd;
  logic                  grant_wr;
  logic                  last_was_wr;
  logic [SRAM_RD_LAT-1:0] rd_pipe;
  logic [SRAM_WR_LAT:0]   wr_pipe_v;
  logic [DATA_WIDTH-1:0]  wr_pipe_d [0:SRAM_WR_LAT];

  always_comb begin
    rd_elig  = rd_0_req & ~rd_0_ack;
    wr_elig  = wr_0_req & ~wr_0_ack;
    grant_rd = rd_elig & (~wr_elig | last_was_wr);
    grant_wr = wr_elig & (~rd_elig | ~last_was_wr);
  end

  // The final write-pipe stage is the pad-facing register; it only loads on a valid
  // write so the bus data holds between writes.
  assign sram_tri_en  = wr_pipe_v[SRAM_WR_LAT];
  assign sram_wr_data = wr_pipe_d[SRAM_WR_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_0_ack    <= 1'b0;
      wr_0_ack    <= 1'b0;
      rd_0_vld    <= 1'b0;
      rd_0_data   <= '0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      last_was_wr <= 1'b1;
      rd_pipe     <= '0;
      wr_pipe_v   <= '0;
      for (int i = 0; i <= SRAM_WR_LAT; i++) begin
        wr_pipe_d[i] <= '0;
      end
    end else begin
      rd_0_ack  <= grant_rd;
      wr_0_ack  <= grant_wr;
      sram_we_n <= ~grant_wr;
      if (grant_wr) begin
        sram_addr <= wr_0_addr;
      end else if (grant_rd) begin
        sram_addr <= rd_0_addr;
      end
      if (grant_rd | grant_wr) begin
        last_was_wr <= grant_wr;
      end

      // rd_pipe[0] is set the cycle after issue, so the last stage lines up with
      // the SRAM data-valid cycle.
      rd_pipe[0] <= rd_0_ack;
      for (int i = 1; i < SRAM_RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      rd_0_vld <= rd_pipe[SRAM_RD_LAT-1];
      if (rd_pipe[SRAM_RD_LAT-1]) begin
        rd_0_data <= sram_rd_data;
      end

      wr_pipe_v[0] <= grant_wr;
      if (grant_wr) begin
        wr_pipe_d[0] <= wr_0_data;
      end
      for (int i = 1; i <= SRAM_WR_LAT; i++) begin
        wr_pipe_v[i] <= wr_pipe_v[i-1];
        if (wr_pipe_v[i-1]) begin
          wr_pipe_d[i] <= wr_pipe_d[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_req_responder.sv
// Directed bench for sram_req_responder with a latency-2 ZBT SRAM model.
module tb_sram_req_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_0_req;
  logic [18:0] rd_0_addr;
  logic        rd_0_ack;
  logic [63:0] rd_0_data;
  logic        rd_0_vld;
  logic        wr_0_req;
  logic [18:0] wr_0_addr;
  logic [63:0] wr_0_data;
  logic        wr_0_ack;
  logic [18:0] sram_addr;
  logic        sram_we_n;
  logic [63:0] sram_wr_data;
  logic        sram_tri_en;
  logic [63:0] sram_rd_data;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  sram_req_responder dut (
    .clk(clk), .reset(reset),
    .rd_0_req(rd_0_req), .rd_0_addr(rd_0_addr), .rd_0_ack(rd_0_ack),
    .rd_0_data(rd_0_data), .rd_0_vld(rd_0_vld),
    .wr_0_req(wr_0_req), .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data),
    .wr_0_ack(wr_0_ack),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_wr_data(sram_wr_data),
    .sram_tri_en(sram_tri_en), .sram_rd_data(sram_rd_data)
  );

  // SRAM model: read data two cycles after the address cycle, write data taken
  // two cycles after a write address cycle when the bus is driven.
  logic [63:0] mem [0:255];
  logic [18:0] a_sh1, a_sh2;
  logic        w_sh1, w_sh2;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr;
  logic [63:0] pre_data;

  always @(posedge clk) begin
    a_sh1 <= sram_addr;
    a_sh2 <= a_sh1;
    w_sh1 <= ~sram_we_n;
    w_sh2 <= w_sh1;
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (w_sh2 && sram_tri_en) mem[a_sh2[7:0]] <= sram_wr_data;
  end
  assign sram_rd_data = mem[a_sh2[7:0]];

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [63:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset;
    step();
    checks++; if (rd_0_ack !== 1'b0) begin failures++; $display("FAIL reset_rd_ack got=%0h exp=0", rd_0_ack); end
    checks++; if (wr_0_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack got=%0h exp=0", wr_0_ack); end
    checks++; if (rd_0_vld !== 1'b0) begin failures++; $display("FAIL reset_rd_vld got=%0h exp=0", rd_0_vld); end
    checks++; if (sram_tri_en !== 1'b0) begin failures++; $display("FAIL reset_tri_en got=%0h exp=0", sram_tri_en); end
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%0h exp=1", sram_we_n); end
    checks++; if (sram_addr !== 19'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", sram_addr); end
    checks++; if (rd_0_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_0_data); end
    checks++; if (sram_wr_data !== 64'h0) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", sram_wr_data); end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    rd_0_req = 1'b1; rd_0_addr = 19'h0C;
    step();
    checks++; if (rd_0_ack !== 1'b1) begin failures++; $display("FAIL read_ack got=%0h exp=1", rd_0_ack); end
    checks++; if (sram_addr !== 19'h0C) begin failures++; $display("FAIL read_addr got=%0h exp=c", sram_addr); end
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL read_we_n got=%0h exp=1", sram_we_n); end
    checks++; if (wr_0_ack !== 1'b0) begin failures++; $display("FAIL read_wr_ack got=%0h exp=0", wr_0_ack); end
    rd_0_req = 1'b0;
    step();
    checks++; if (rd_0_ack !== 1'b0) begin failures++; $display("FAIL read_ack_pulse got=%0h exp=0", rd_0_ack); end
    step();
    checks++; if (rd_0_vld !== 1'b0) begin failures++; $display("FAIL read_vld_early got=%0h exp=0", rd_0_vld); end
    step();
    checks++; if (rd_0_vld !== 1'b1) begin failures++; $display("FAIL read_vld got=%0h exp=1", rd_0_vld); end
    checks++; if (rd_0_data !== 64'hDEADBEEF_00000050) begin failures++; $display("FAIL read_data got=%0h exp=deadbeef00000050", rd_0_data); end
    step();
    checks++; if (rd_0_vld !== 1'b0) begin failures++; $display("FAIL read_vld_pulse got=%0h exp=0", rd_0_vld); end
    checks++; if (rd_0_data !== 64'hDEADBEEF_00000050) begin failures++; $display("FAIL read_data_hold got=%0h exp=deadbeef00000050", rd_0_data); end
  endtask

  task automatic test_single_write;
    wr_0_req = 1'b1; wr_0_addr = 19'h4; wr_0_data = 64'h1234;
    step();
    checks++; if (wr_0_ack !== 1'b1) begin failures++; $display("FAIL write_ack got=%0h exp=1", wr_0_ack); end
    checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL write_we_n got=%0h exp=0", sram_we_n); end
    checks++; if (sram_addr !== 19'h4) begin failures++; $display("FAIL write_addr got=%0h exp=4", sram_addr); end
    wr_0_req = 1'b0; wr_0_data = 64'h0;
    step();
    checks++; if (sram_tri_en !== 1'b0) begin failures++; $display("FAIL write_tri_early got=%0h exp=0", sram_tri_en); end
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL write_we_n_idle got=%0h exp=1", sram_we_n); end
    checks++; if (sram_addr !== 19'h4) begin failures++; $display("FAIL write_addr_hold got=%0h exp=4", sram_addr); end
    step();
    checks++; if (sram_tri_en !== 1'b1) begin failures++; $display("FAIL write_tri_en got=%0h exp=1", sram_tri_en); end
    checks++; if (sram_wr_data !== 64'h1234) begin failures++; $display("FAIL write_data got=%0h exp=1234", sram_wr_data); end
    step();
    checks++; if (sram_tri_en !== 1'b0) begin failures++; $display("FAIL write_tri_pulse got=%0h exp=0", sram_tri_en); end
    checks++; if (sram_wr_data !== 64'h1234) begin failures++; $display("FAIL write_data_hold got=%0h exp=1234", sram_wr_data); end
    rd_0_req = 1'b1; rd_0_addr = 19'h4;
    step();
    checks++; if (rd_0_ack !== 1'b1) begin failures++; $display("FAIL readback_ack got=%0h exp=1", rd_0_ack); end
    rd_0_req = 1'b0;
    step(); step(); step();
    checks++; if (rd_0_vld !== 1'b1) begin failures++; $display("FAIL readback_vld got=%0h exp=1", rd_0_vld); end
    checks++; if (rd_0_data !== 64'h1234) begin failures++; $display("FAIL readback_data got=%0h exp=1234", rd_0_data); end
  endtask

  task automatic test_addr_passthrough;
    wr_0_req = 1'b1; wr_0_addr = 19'h7FFFF; wr_0_data = 64'hBEEF;
    step();
    checks++; if (sram_addr !== 19'h7FFFF) begin failures++; $display("FAIL wrap_wr_addr got=%0h exp=7ffff", sram_addr); end
    checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL wrap_we_n got=%0h exp=0", sram_we_n); end
    wr_0_req = 1'b0;
    step(); step();
    rd_0_req = 1'b1; rd_0_addr = 19'h7FFFF;
    step();
    checks++; if (rd_0_ack !== 1'b1 || sram_addr !== 19'h7FFFF) begin failures++; $display("FAIL wrap_rd_issue got=%0h/%0h exp=1/7ffff", rd_0_ack, sram_addr); end
    rd_0_req = 1'b0;
    step(); step(); step();
    checks++; if (rd_0_vld !== 1'b1 || rd_0_data !== 64'hBEEF) begin failures++; $display("FAIL wrap_rd_data got=%0h/%0h exp=1/beef", rd_0_vld, rd_0_data); end
  endtask

  task automatic test_contention;
    logic exp_rd;
    logic exp_vld;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_0_req = 1'b1; rd_0_addr = 19'h10;
    wr_0_req = 1'b1; wr_0_addr = 19'h20; wr_0_data = 64'hAA;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_rd  = (k <= 6) && (k % 2 == 1);
      exp_vld = (k == 4) || (k == 6) || (k == 8);
      checks++; if (rd_0_ack !== exp_rd) begin failures++; $display("FAIL contend_rd_ack k=%0d got=%0h exp=%0h", k, rd_0_ack, exp_rd); end
      checks++; if (wr_0_ack !== ((k <= 6) && !exp_rd)) begin failures++; $display("FAIL contend_wr_ack k=%0d got=%0h exp=%0h", k, wr_0_ack, (k <= 6) && !exp_rd); end
      if (k <= 6) begin
        checks++; if (sram_addr !== (exp_rd ? 19'h10 : 19'h20)) begin failures++; $display("FAIL contend_addr k=%0d got=%0h exp=%0h", k, sram_addr, exp_rd ? 19'h10 : 19'h20); end
        checks++; if (sram_we_n !== exp_rd) begin failures++; $display("FAIL contend_we_n k=%0d got=%0h exp=%0h", k, sram_we_n, exp_rd); end
      end
      checks++; if (rd_0_vld !== exp_vld) begin failures++; $display("FAIL contend_vld k=%0d got=%0h exp=%0h", k, rd_0_vld, exp_vld); end
      if (exp_vld) begin
        checks++; if (rd_0_data !== 64'h5555_0000_0000_0010) begin failures++; $display("FAIL contend_data k=%0d got=%0h exp=5555000000000010", k, rd_0_data); end
      end
      if (k == 6) begin
        rd_0_req = 1'b0;
        wr_0_req = 1'b0;
      end
    end
  endtask

  task automatic test_scan;
    logic [18:0] addrs [4];
    logic [63:0] exps [4];
    int n_ack, n_vld;
    addrs[0] = 19'h0; addrs[1] = 19'h4; addrs[2] = 19'h8; addrs[3] = 19'hC;
    exps[0] = 64'h0123_4567_89AB_CDEF; exps[1] = 64'h1234;
    exps[2] = 64'hCAFE_F00D_0000_0008; exps[3] = 64'hDEADBEEF_00000050;
    n_ack = 0; n_vld = 0;
    rd_0_req = 1'b1; rd_0_addr = addrs[0];
    for (int k = 1; k <= 14; k++) begin
      step();
      if (rd_0_ack) begin
        checks++; if (k !== 1 + 2 * n_ack) begin failures++; $display("FAIL scan_ack_cycle n=%0d got=%0d exp=%0d", n_ack, k, 1 + 2 * n_ack); end
        checks++; if (n_ack < 4 && sram_addr !== addrs[n_ack]) begin failures++; $display("FAIL scan_addr n=%0d got=%0h exp=%0h", n_ack, sram_addr, addrs[n_ack]); end
        n_ack++;
        if (n_ack < 4) rd_0_addr = addrs[n_ack];
        else rd_0_req = 1'b0;
      end
      if (rd_0_vld) begin
        checks++; if (n_vld >= 4 || rd_0_data !== exps[n_vld]) begin failures++; $display("FAIL scan_data n=%0d got=%0h exp=%0h", n_vld, rd_0_data, exps[n_vld % 4]); end
        n_vld++;
      end
    end
    checks++; if (n_ack !== 4) begin failures++; $display("FAIL scan_ack_count got=%0d exp=4", n_ack); end
    checks++; if (n_vld !== 4) begin failures++; $display("FAIL scan_vld_count got=%0d exp=4", n_vld); end
  endtask

  task automatic test_lockout;
    logic exp_ack;
    logic exp_vld;
    rd_0_req = 1'b1; rd_0_addr = 19'h8;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_ack = (k <= 8) && (k % 2 == 1);
      exp_vld = (k == 4) || (k == 6) || (k == 8) || (k == 10);
      checks++; if (rd_0_ack !== exp_ack) begin failures++; $display("FAIL lockout_ack k=%0d got=%0h exp=%0h", k, rd_0_ack, exp_ack); end
      checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL lockout_we_n k=%0d got=%0h exp=1", k, sram_we_n); end
      checks++; if (rd_0_vld !== exp_vld) begin failures++; $display("FAIL lockout_vld k=%0d got=%0h exp=%0h", k, rd_0_vld, exp_vld); end
      if (exp_vld) begin
        checks++; if (rd_0_data !== 64'hCAFE_F00D_0000_0008) begin failures++; $display("FAIL lockout_data k=%0d got=%0h exp=cafef00d00000008", k, rd_0_data); end
      end
      if (k == 8) rd_0_req = 1'b0;
    end
  endtask

  task automatic test_reset_midflight;
    rd_0_req = 1'b1; rd_0_addr = 19'h8;
    step();
    checks++; if (rd_0_ack !== 1'b1) begin failures++; $display("FAIL midrst_rd_ack got=%0h exp=1", rd_0_ack); end
    rd_0_req = 1'b0;
    wr_0_req = 1'b1; wr_0_addr = 19'h30; wr_0_data = 64'h77;
    step();
    checks++; if (wr_0_ack !== 1'b1) begin failures++; $display("FAIL midrst_wr_ack got=%0h exp=1", wr_0_ack); end
    wr_0_req = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (rd_0_ack !== 1'b0 || wr_0_ack !== 1'b0) begin failures++; $display("FAIL midrst_acks got=%0h/%0h exp=0/0", rd_0_ack, wr_0_ack); end
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL midrst_we_n got=%0h exp=1", sram_we_n); end
    checks++; if (sram_addr !== 19'h0) begin failures++; $display("FAIL midrst_addr got=%0h exp=0", sram_addr); end
    checks++; if (rd_0_data !== 64'h0) begin failures++; $display("FAIL midrst_rd_data got=%0h exp=0", rd_0_data); end
    checks++; if (sram_wr_data !== 64'h0) begin failures++; $display("FAIL midrst_wr_data got=%0h exp=0", sram_wr_data); end
    checks++; if (rd_0_vld !== 1'b0 || sram_tri_en !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%0h/%0h exp=0/0", rd_0_vld, sram_tri_en); end
    reset = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      step();
      checks++; if (rd_0_vld !== 1'b0) begin failures++; $display("FAIL midrst_stale_vld k=%0d got=%0h exp=0", k, rd_0_vld); end
      checks++; if (sram_tri_en !== 1'b0) begin failures++; $display("FAIL midrst_stale_tri k=%0d got=%0h exp=0", k, sram_tri_en); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_0_req = 1'b0; rd_0_addr = '0;
    wr_0_req = 1'b0; wr_0_addr = '0; wr_0_data = '0;
    preload(8'h00, 64'h0123_4567_89AB_CDEF);
    preload(8'h04, 64'h0BAD_0BAD_0BAD_0BAD);
    preload(8'h08, 64'hCAFE_F00D_0000_0008);
    preload(8'h0C, 64'hDEADBEEF_00000050);
    preload(8'h10, 64'h5555_0000_0000_0010);
    test_reset();
    step();
    test_single_read();
    step(); step();
    test_single_write();
    step(); step();
    test_addr_passthrough();
    step(); step();
    test_contention();
    step(); step();
    test_scan();
    step(); step();
    test_lockout();
    step(); step();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_req_responder.md
# sram_req_responder

Responder side of the user-datapath SRAM request interface (`rd_0_*` / `wr_0_*`). It accepts single-word read and write requests from one datapath module, arbitrates between them, and drives a pipelined ZBT SRAM. It returns acknowledges and read data with fixed latency. It sits between the user datapath module (for example, a rule-table lookup stage) and the SRAM pins.

## Interface
Parameters:
- `DATA_WIDTH`, 64: request and SRAM data width.
- `SRAM_ADDR_WIDTH`, 19: word address width.
- `SRAM_RD_LAT`, 2: cycles from the SRAM address cycle to valid `sram_rd_data`. Legal range 1–4.
- `SRAM_WR_LAT`, 2: cycles from the SRAM address cycle to driving write data. Legal range 1–4.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `rd_0_req`, in, 1: read request, held until acknowledged.
- `rd_0_addr`, in, `SRAM_ADDR_WIDTH`: read address, stable while `rd_0_req` is high.
- `rd_0_ack`, out, 1: one-cycle pulse; read issued to SRAM this cycle.
- `rd_0_data`, out, `DATA_WIDTH`: read data, valid with `rd_0_vld`.
- `rd_0_vld`, out, 1: one-cycle pulse per completed read.
- `wr_0_req`, in, 1: write request, held until acknowledged.
- `wr_0_addr`, in, `SRAM_ADDR_WIDTH`: write address.
- `wr_0_data`, in, `DATA_WIDTH`: write data.
- `wr_0_ack`, out, 1: one-cycle pulse; write issued to SRAM this cycle.
- `sram_addr`, out, `SRAM_ADDR_WIDTH`: SRAM address.
- `sram_we_n`, out, 1: active-low write enable, qualified by the address cycle.
- `sram_wr_data`, out, `DATA_WIDTH`: write data to the pad tristate.
- `sram_tri_en`, out, 1: high means the FPGA drives the SRAM data bus.
- `sram_rd_data`, in, `DATA_WIDTH`: SRAM read data.

## Operation
- One SRAM operation (read or write) is issued per cycle at most. ZBT needs no bus turnaround, so back-to-back read and write are legal.
- **Grant decision (combinational, cycle t):**
  - A port is eligible if its req is high and its ack is not high in cycle t.
  - This lockout rule masks the stale request still held by a registered requester in its ack cycle.
- **Arbitration:**
  - If only one port is eligible, it wins.
  - If both are eligible, the port not granted last wins. The `last_was_wr` flag resets to 1, so reads win the first tie.
  - `last_was_wr` updates on every grant.
- **Issue (registered, cycle t+1):**
  - `sram_addr` takes the granted address.
  - `sram_we_n` is 0 for a write and 1 otherwise.
  - The matching ack pulses high for exactly this cycle.
  - For a write, `wr_0_data` is captured into the write pipeline at the grant edge.
- **Read return:**
  - A read-flag shift register of depth `SRAM_RD_LAT` tracks issued reads.
  - `sram_rd_data` is registered into `rd_0_data`. `rd_0_vld` pulses at issue cycle + `SRAM_RD_LAT` + 1.
  - `rd_0_data` holds its last value between pulses.
- **Write data:**
  - At issue cycle + `SRAM_WR_LAT`, `sram_wr_data` carries the captured data and `sram_tri_en` is 1 for one cycle per write.
  - Otherwise `sram_tri_en` is 0 and `sram_wr_data` holds its last value.
- **Idle cycles:** `sram_we_n` = 1 and `sram_addr` holds the last issued address.
- **Ordering:** completions return in issue order. Up to `SRAM_RD_LAT` reads may be in flight.
- There is no back-pressure on `rd_0_vld`. The requester must accept every pulse.

## Timing
- **Reset values:**
  - `rd_0_ack`, `wr_0_ack`, `rd_0_vld`, `sram_tri_en` = 0.
  - `sram_we_n` = 1.
  - `sram_addr`, `rd_0_data`, `sram_wr_data` = 0.
  - Read/write pipelines and `last_was_wr` cleared (`last_was_wr` = 1).
- **Latency:**
  - req high at t → ack at t+1 when there is no contention.
  - Read vld at t+1+`SRAM_RD_LAT`+1, which is t+4 at defaults.
- **Throughput:**
  - A single port reaches at most one grant every 2 cycles, because of the lockout.
  - Both ports interleaved can reach 1 op/cycle.
- **Simultaneous requests:** the loser keeps its req high. It is granted on the next cycle, because the winner is locked out then.
- **Reset mid-operation:** all in-flight reads and writes are discarded. No vld or `tri_en` pulse follows reset for an operation issued before reset.
- **Deassertion:** a req dropped before grant is never issued. Req dropped in its ack cycle is the expected behaviour.
- **Address wrap:** `sram_addr` passes `rd_0_addr`/`wr_0_addr` through unmodified. There is no increment logic.

## Test plan
- **Single read:** preload SRAM model word `0x0C` = `0xDEADBEEF_00000050`; hold `rd_0_req` with addr `0x0C` from t=10.
  - Expect `rd_0_ack` at 11.
  - Expect `sram_addr` = `0x0C`, `sram_we_n` = 1 at 11.
  - Expect `rd_0_vld` at 14 with that data.
- **Single write:** `wr_0_addr` = `0x4`, data = `0x1234` requested at t=20.
  - Expect `wr_0_ack` and `sram_we_n` = 0 at 21.
  - Expect `sram_tri_en` = 1, `sram_wr_data` = `0x1234` at 23.
  - A read of `0x4` afterwards returns `0x1234`.
- **Contention:** after reset, both reqs rise at t=30.
  - Expect a read ack at 31 and a write ack at 32.
  - Hold both high continuously: acks alternate R, W, R, W on consecutive cycles.
- **Rule-table scan:** four reads at addresses 0, 4, 8, `0xC`, with the requester re-asserting req with a new address after each ack.
  - Expect 4 acks, 2 cycles apart.
  - Expect 4 `rd_0_vld` pulses in address order, each carrying the preloaded data.
- **Reset mid-flight:** issue a read at t=50 (ack at 51) and assert reset at 52.
  - No `rd_0_vld` from that read.
  - All outputs at reset values from 53.
- **Lockout:** the requester holds `rd_0_req` high through its ack cycle without changing address.
  - Exactly one ack per 2 cycles.
  - No duplicate issue within an ack cycle.
